// File: rtl/rk4_param_loader_if.sv
// Operand handshake bundle between the parameter loader and its consumer.
// The loader drives the operand set and VALID; the consumer returns ACK.
interface rk4_param_loader_if #(
    parameter int n = 32
);
    logic         VALID;
    logic         ACK;
    logic [n-1:0] X0;
    logic [n-1:0] Y0;
    logic [n-1:0] C;
    logic [n-1:0] N;

    modport master (
        output VALID, X0, Y0, C, N,
        input  ACK
    );

    modport slave (
        input  VALID, X0, Y0, C, N,
        output ACK
    );
endinterface

// File: rtl/rk4_param_loader.sv
// Switch/button operand loader for the RK4 core: eight 16-bit halves
// are entered by hand, then offered to the consumer on a GO press.
module rk4_param_loader #(
    parameter int DB_CYCLES = 4,
    parameter int n         = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [15:0]        SW,
    input  logic               BTN_LD,
    input  logic               BTN_GO,
    rk4_param_loader_if.master bus,
    output logic [2:0]         IDX,
    output logic               ARMED,
    output logic               N_ZERO
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] DB_FULL = CW'(DB_CYCLES);

    typedef enum logic [1:0] {ENTRY, ARM, REQ} state_t;

    state_t        r_state;
    logic [15:0]   r_sw_s1, r_sw_s2;
    logic          r_ld_s1, r_ld_s2;
    logic          r_go_s1, r_go_s2;
    logic [CW-1:0] r_ld_cnt, r_go_cnt;
    logic [2:0]    r_idx;
    logic          r_armed;
    logic          r_valid;
    logic [n-1:0]  r_x0, r_y0, r_c, r_n;
    logic          w_ld_ev, w_go_ev, w_n_zero;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
            r_ld_s1 <= 1'b0;
            r_ld_s2 <= 1'b0;
            r_go_s1 <= 1'b0;
            r_go_s2 <= 1'b0;
        end else begin
            r_sw_s1 <= SW;
            r_sw_s2 <= r_sw_s1;
            r_ld_s1 <= BTN_LD;
            r_ld_s2 <= r_ld_s1;
            r_go_s1 <= BTN_GO;
            r_go_s2 <= r_go_s1;
        end
    end

    // Counters saturate at DB_CYCLES so a long hold yields a single event.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_ld_cnt <= '0;
            r_go_cnt <= '0;
        end else begin
            if (!r_ld_s2)
                r_ld_cnt <= '0;
            else if (r_ld_cnt != DB_FULL)
                r_ld_cnt <= r_ld_cnt + CW'(1);
            if (!r_go_s2)
                r_go_cnt <= '0;
            else if (r_go_cnt != DB_FULL)
                r_go_cnt <= r_go_cnt + CW'(1);
        end
    end

    assign w_ld_ev  = r_ld_s2 && (r_ld_cnt == DB_LAST);
    assign w_go_ev  = r_go_s2 && (r_go_cnt == DB_LAST);
    assign w_n_zero = (r_n == '0);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= ENTRY;
            r_idx   <= 3'd0;
            r_armed <= 1'b0;
            r_valid <= 1'b0;
            r_x0    <= '0;
            r_y0    <= '0;
            r_c     <= '0;
            r_n     <= '0;
        end else begin
            case (r_state)
                ENTRY: begin
                    if (w_ld_ev) begin
                        case (r_idx)
                            3'd0: r_x0[n-1 -: 16] <= r_sw_s2;
                            3'd1: r_x0[15:0]      <= r_sw_s2;
                            3'd2: r_y0[n-1 -: 16] <= r_sw_s2;
                            3'd3: r_y0[15:0]      <= r_sw_s2;
                            3'd4: r_c[n-1 -: 16]  <= r_sw_s2;
                            3'd5: r_c[15:0]       <= r_sw_s2;
                            3'd6: r_n[n-1 -: 16]  <= r_sw_s2;
                            3'd7: r_n[15:0]       <= r_sw_s2;
                        endcase
                        if (r_idx == 3'd7) begin
                            r_idx   <= 3'd0;
                            r_armed <= 1'b1;
                            r_state <= ARM;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                ARM: begin
                    // A usable GO beats a simultaneous LD.
                    if (w_go_ev && !w_n_zero) begin
                        r_valid <= 1'b1;
                        r_state <= REQ;
                    end else if (w_ld_ev) begin
                        r_x0[n-1 -: 16] <= r_sw_s2;
                        r_idx           <= 3'd1;
                        r_armed         <= 1'b0;
                        r_state         <= ENTRY;
                    end
                end
                REQ: begin
                    if (bus.ACK) begin
                        r_valid <= 1'b0;
                        r_state <= ARM;
                    end
                end
                default: begin
                    r_state <= ENTRY;
                    r_idx   <= 3'd0;
                    r_armed <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.VALID = r_valid;
    assign bus.X0    = r_x0;
    assign bus.Y0    = r_y0;
    assign bus.C     = r_c;
    assign bus.N     = r_n;
    assign IDX       = r_idx;
    assign ARMED     = r_armed;
    assign N_ZERO    = w_n_zero;
endmodule
